// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_bus_arbiter
//  Purpose  : Shares the peripheral I2C bus between the external host (via the
//             SDA/SCL passthrough bridge) and an internal FPGA I2C master. The
//             host bus is watched for START/STOP; the internal master is only
//             granted the bus after the host side has been idle for
//             BUS_FREE_CYCLES, and the bridge is blocked while it owns it.
//  Ports    : ICE_CLK/ICE_RST   - clock, asynchronous active-high reset
//             global_scl_di/sda - raw host-side bus levels (asynchronous)
//             int_req/int_done  - internal master request level / done pulse
//             passthru_en       - bridge enable (0 blocks forwarding)
//             int_grant         - internal master owns the bus
//             ext_busy          - host transaction in progress
//             bus_stuck         - sticky timeout flag
//  Options  : define I2C_ARB_TIMEOUT_EN to add stuck-bus / stuck-grant
//             timeouts; otherwise bus_stuck is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_arbiter #(
    parameter int BUS_FREE_CYCLES = 64,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic ICE_CLK,
    input  logic ICE_RST,
    input  logic global_scl_di,
    input  logic global_sda_di,
    input  logic int_req,
    input  logic int_done,
    output logic passthru_en,
    output logic int_grant,
    output logic ext_busy,
    output logic bus_stuck
);

    localparam logic [2:0] c_FREE_WAIT = 3'd0;
    localparam logic [2:0] c_IDLE      = 3'd1;
    localparam logic [2:0] c_EXT_BUSY  = 3'd2;
    localparam logic [2:0] c_INT_GRANT = 3'd3;
    localparam logic [2:0] c_DRAIN     = 3'd4;

    localparam logic [CNT_W-1:0] c_FREE_LAST = CNT_W'(BUS_FREE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    // Both counters must be able to hold their limits without wrapping.
    if (((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) || (BUS_FREE_CYCLES < 1) ||
        ((64'd1 << CNT_W) <= 64'(BUS_FREE_CYCLES))) begin : g_cnt_w_check
        $error("i2c_bus_arbiter: CNT_W too narrow for the configured limits");
    end

    // Synchronizer + history stages; idle bus level is 1 so all reset to 1.
    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;
    logic start_q, stop_q;
    logic [2:0] state_q, state_d;
    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
    logic passthru_q, grant_q, busy_q;

    logic w_start, w_stop, w_lines_high, w_free_done;

    always_ff @(posedge ICE_CLK or posedge ICE_RST) begin
        if (ICE_RST) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= global_scl_di;
            scl_sync_q <= scl_meta_q;
            scl_hist_q <= scl_sync_q;
            sda_meta_q <= global_sda_di;
            sda_sync_q <= sda_meta_q;
            sda_hist_q <= sda_sync_q;
        end
    end

    // SCL must be high in both stages so an SDA change coinciding with an SCL
    // edge is never mistaken for a bus condition.
    assign w_start      = sda_hist_q & ~sda_sync_q & scl_hist_q & scl_sync_q;
    assign w_stop       = ~sda_hist_q & sda_sync_q & scl_hist_q & scl_sync_q;
    assign w_lines_high = scl_sync_q & sda_sync_q;
    // True on the cycle whose count makes the run reach BUS_FREE_CYCLES.
    assign w_free_done  = w_lines_high && (free_cnt_q >= c_FREE_LAST);

    always_ff @(posedge ICE_CLK or posedge ICE_RST) begin
        if (ICE_RST) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            start_q <= w_start;
            stop_q  <= w_stop;
        end
    end

    // Bus-free run counter: only meaningful while waiting for a free bus.
    always_comb begin
        free_cnt_d = '0;
        if (((state_q == c_FREE_WAIT) || (state_q == c_DRAIN)) && w_lines_high) begin
            free_cnt_d = (free_cnt_q == c_CNT_MAX) ? free_cnt_q : free_cnt_q + 1'b1;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic stuck_q, stuck_d;
    logic w_activity, w_timeout;

    assign w_activity = (scl_sync_q ^ scl_hist_q) | (sda_sync_q ^ sda_hist_q);
    assign w_timeout  = (to_cnt_q >= c_TO_LAST);

    // In EXT_BUSY this is a bus-inactivity count; in INT_GRANT it ages the
    // grant. It is cleared in every other state.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == c_EXT_BUSY) begin
            to_cnt_d = w_activity ? '0 :
                       ((to_cnt_q == c_CNT_MAX) ? to_cnt_q : to_cnt_q + 1'b1);
        end else if (state_q == c_INT_GRANT) begin
            to_cnt_d = (to_cnt_q == c_CNT_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ICE_CLK or posedge ICE_RST) begin
        if (ICE_RST) begin
            to_cnt_q <= '0;
            stuck_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            stuck_q  <= stuck_d;
        end
    end

    assign bus_stuck = stuck_q;
`else
    assign bus_stuck = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
`ifdef I2C_ARB_TIMEOUT_EN
        stuck_d = stuck_q;
`endif
        case (state_q)
            c_FREE_WAIT: begin
                if (start_q)          state_d = c_EXT_BUSY;
                else if (w_free_done) state_d = c_IDLE;
            end
            c_IDLE: begin
                // Host START takes priority over a same-cycle request.
                if (start_q)      state_d = c_EXT_BUSY;
                else if (int_req) state_d = c_INT_GRANT;
            end
            c_EXT_BUSY: begin
                if (stop_q) state_d = c_FREE_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                else if (w_timeout) begin
                    state_d = c_FREE_WAIT;
                    stuck_d = 1'b1;
                end
`endif
            end
            c_INT_GRANT: begin
                // Host conditions are ignored: the bridge is blocked.
                if (int_done || !int_req) state_d = c_DRAIN;
`ifdef I2C_ARB_TIMEOUT_EN
                else if (w_timeout) begin
                    state_d = c_DRAIN;
                    stuck_d = 1'b1;
                end
`endif
            end
            c_DRAIN: begin
                if (w_free_done) state_d = c_IDLE;
            end
            default: state_d = c_FREE_WAIT;
        endcase
    end

    // Outputs are registered decodes of the next state so they change on the
    // same edge as the state and never glitch.
    always_ff @(posedge ICE_CLK or posedge ICE_RST) begin
        if (ICE_RST) begin
            state_q    <= c_FREE_WAIT;
            free_cnt_q <= '0;
            passthru_q <= 1'b1;
            grant_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            free_cnt_q <= free_cnt_d;
            passthru_q <= !((state_d == c_INT_GRANT) || (state_d == c_DRAIN));
            grant_q    <= (state_d == c_INT_GRANT);
            busy_q     <= (state_d == c_EXT_BUSY);
        end
    end

    assign passthru_en = passthru_q;
    assign int_grant   = grant_q;
    assign ext_busy    = busy_q;

endmodule
`default_nettype wire
